// File: rtl/fft_sequencer.sv
// fft_sequencer: control FSM that loads N samples per stage, triggers coefficient fill and stage compute, and tracks completion.
module fft_sequencer #(
    parameter int N        = 32,
    parameter int MSB      = 16,
    parameter int FILL_CYC = N / 2 + 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sample_valid,
    input  logic [MSB-1:0]         sample_in,
    output logic                   sample_ready,
    input  logic                   calc_finish,
    output logic                   fill_regs,
    output logic                   we_regs,
    output logic [MSB-1:0]         data_in,
    output logic [$clog2(N)-1:0]   addr_counter,
    output logic [$clog2(N/2)-1:0] stage,
    output logic                   start_calc,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);
    localparam int AW   = $clog2(N);
    localparam int SW   = $clog2(N / 2);
    localparam int NSTG = $clog2(N);
    localparam int CMAX = (TIMEOUT > FILL_CYC) ? TIMEOUT : FILL_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CFILL, S_CALC, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_cnt;
    logic [CW-1:0]   r_cyc;
    logic [SW-1:0]   r_stage;
    logic [MSB-1:0]  r_data;
    logic            r_tmo;
    logic            r_fill;
    logic            r_start_calc;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_last_fill;
    logic            w_tmo;
    logic            w_last_stg;

    assign w_accept     = (r_state == S_LOAD) && sample_valid;
    assign w_last_fill  = r_cyc == CW'(FILL_CYC - 1);
    assign w_tmo        = r_cyc == CW'(TIMEOUT - 1);
    assign w_last_stg   = r_stage == SW'(NSTG - 1);
    assign sample_ready = r_state == S_LOAD;
    assign we_regs      = w_accept;
    assign addr_counter = r_cnt;
    // The held sample register drives the output, bypassed by the live sample during an accept.
    assign data_in      = w_accept ? sample_in : r_data;
    assign stage        = r_stage;
    assign fill_regs    = r_fill;
    assign start_calc   = r_start_calc;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout_err  = r_tmo;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; calc_finish wins over a coincident timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = (w_accept && r_cnt == AW'(N - 1)) ? S_CFILL : S_LOAD;
            S_CFILL: w_next = w_last_fill ? S_CALC : S_CFILL;
            S_CALC:  w_next = S_WAIT;
            S_WAIT:  w_next = calc_finish ? (w_last_stg ? S_DONE : S_LOAD) : (w_tmo ? S_IDLE : S_WAIT);
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Load count, dwell counter, stage index, sample hold and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_cyc   <= '0;
            r_stage <= '0;
            r_data  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_stage <= '0;
                r_cnt   <= '0;
                r_tmo   <= 1'b0;
            end
            if (w_accept) begin
                r_cnt  <= (r_cnt == AW'(N - 1)) ? '0 : r_cnt + AW'(1);
                r_data <= sample_in;
            end
            r_cyc <= (w_next == r_state && (r_state == S_CFILL || r_state == S_WAIT)) ? r_cyc + CW'(1) : '0;
            if (r_state == S_WAIT && calc_finish && !w_last_stg) r_stage <= r_stage + SW'(1);
            if (r_state == S_WAIT && !calc_finish && w_tmo) r_tmo <= 1'b1;
        end
    end

    // Registered control strobes, aligned with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill       <= 1'b0;
            r_start_calc <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_fill       <= (w_next == S_CFILL) && (r_state != S_CFILL);
            r_start_calc <= w_next == S_CALC;
            r_busy       <= w_next != S_IDLE;
            r_done       <= w_next == S_DONE;
        end
    end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed scenarios for fft_sequencer with N=32, FILL_CYC=18, TIMEOUT=1024.
module tb_fft_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic        calc_finish = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_ready, fill_regs, we_regs, start_calc, busy, done, timeout_err;
    logic [15:0] data_in;
    logic [4:0]  addr_counter;
    logic [3:0]  stage;
    int checks = 0, failures = 0;
    int n_fill = 0, n_sc = 0, n_done = 0, n_we = 0, run_bad = 0;

    always #5 clk = ~clk;

    fft_sequencer #(.N(32), .MSB(16), .FILL_CYC(18), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .sample_in(sample_in), .sample_ready(sample_ready), .calc_finish(calc_finish),
        .fill_regs(fill_regs), .we_regs(we_regs), .data_in(data_in),
        .addr_counter(addr_counter), .stage(stage), .start_calc(start_calc),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    // Pulse counters, sampled mid-cycle once inputs have settled.
    always @(negedge clk) begin
        #2;
        if (fill_regs === 1'b1) n_fill++;
        if (start_calc === 1'b1) n_sc++;
        if (done === 1'b1) n_done++;
        if (we_regs === 1'b1) n_we++;
    end

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_stage(input bit gaps, input logic [15:0] base, output int bad, output int cyc);
        int k;
        bit have;
        logic [15:0] prev;
        k = 0; bad = 0; cyc = 0; have = 0; prev = '0;
        while (k < 32 && cyc < 200) begin
            sample_valid = !gaps || (cyc % 2 == 0);
            sample_in = sample_valid ? base + 16'(k) : 16'hDEAD;
            #1;
            if (sample_ready !== 1'b1) bad++;
            if (sample_valid) begin
                if (we_regs !== 1'b1 || data_in !== sample_in || addr_counter !== 5'(k)) bad++;
                prev = sample_in; have = 1; k++;
            end else if (we_regs !== 1'b0 || (have && data_in !== prev)) bad++;
            @(negedge clk);
            cyc++;
        end
        sample_valid = 1'b0;
        if (k != 32) bad++;
    endtask

    task automatic wait_calc(output int cyc);
        cyc = 0;
        while (start_calc !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_after(input int n);
        repeat (n) @(negedge clk);
        calc_finish = 1'b1;
        @(negedge clk);
        calc_finish = 1'b0;
    endtask

    task automatic run_stage(input logic [15:0] base);
        int bad, cyc;
        load_stage(0, base, bad, cyc);
        if (bad != 0) run_bad++;
        wait_calc(cyc);
        if (cyc != 18) run_bad++;
        finish_after(10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({sample_ready, we_regs, fill_regs, start_calc, busy, done, timeout_err} !== 7'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {sample_ready, we_regs, fill_regs, start_calc, busy, done, timeout_err}); end
        checks++; if (data_in !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_in); end
        checks++; if (addr_counter !== 5'd0 || stage !== 4'd0) begin failures++; $display("FAIL reset_addr_stage got=%0d/%0d exp=0/0", addr_counter, stage); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_run;
        int bad, cyc;
        n_fill = 0; n_sc = 0; n_done = 0; n_we = 0;
        do_start;
        checks++; if (busy !== 1'b1 || sample_ready !== 1'b1) begin failures++; $display("FAIL full_start got busy=%b ready=%b exp=1/1", busy, sample_ready); end
        for (int s = 0; s < 5; s++) begin
            checks++; if (stage !== 4'(s)) begin failures++; $display("FAIL full_stage_load got=%0d exp=%0d", stage, s); end
            load_stage(0, 16'(s * 256), bad, cyc);
            checks++; if (bad != 0 || cyc != 32) begin failures++; $display("FAIL full_load got bad=%0d cyc=%0d exp=0/32", bad, cyc); end
            checks++; if (fill_regs !== 1'b1) begin failures++; $display("FAIL full_fill_entry got=%b exp=1", fill_regs); end
            wait_calc(cyc);
            checks++; if (cyc != 18) begin failures++; $display("FAIL full_fill_len got=%0d exp=18", cyc); end
            checks++; if (stage !== 4'(s)) begin failures++; $display("FAIL full_stage_hold got=%0d exp=%0d", stage, s); end
            finish_after(10);
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL full_after_done got done=%b busy=%b exp=0/0", done, busy); end
        checks++; if (n_fill != 5 || n_sc != 5 || n_done != 1) begin failures++; $display("FAIL full_pulses got fill=%0d calc=%0d done=%0d exp=5/5/1", n_fill, n_sc, n_done); end
        checks++; if (n_we != 160) begin failures++; $display("FAIL full_we got=%0d exp=160", n_we); end
    endtask

    task automatic test_backpressure;
        int bad, cyc;
        n_we = 0; n_done = 0;
        do_start;
        load_stage(1, 16'h5000, bad, cyc);
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_accepts got bad=%0d exp=0", bad); end
        checks++; if (cyc != 63) begin failures++; $display("FAIL bp_cycles got=%0d exp=63", cyc); end
        checks++; if (n_we != 32) begin failures++; $display("FAIL bp_we_count got=%0d exp=32", n_we); end
        checks++; if (fill_regs !== 1'b1 || sample_ready !== 1'b0 || addr_counter !== 5'd0) begin failures++; $display("FAIL bp_cfill got fill=%b ready=%b addr=%0d exp=1/0/0", fill_regs, sample_ready, addr_counter); end
        wait_calc(cyc);
        finish_after(10);
        checks++; if (stage !== 4'd1 || sample_ready !== 1'b1) begin failures++; $display("FAIL bp_next_stage got stage=%0d ready=%b exp=1/1", stage, sample_ready); end
    endtask

    task automatic test_timeout;
        int bad, cyc;
        run_bad = 0;
        run_stage(16'h6000);
        checks++; if (stage !== 4'd2 || run_bad != 0) begin failures++; $display("FAIL to_reach_stage2 got stage=%0d bad=%0d exp=2/0", stage, run_bad); end
        load_stage(0, 16'h6200, bad, cyc);
        wait_calc(cyc);
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 1100) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != 1025) begin failures++; $display("FAIL to_latency got=%0d exp=1025", cyc); end
        checks++; if (busy !== 1'b0 || n_done != 0) begin failures++; $display("FAIL to_idle got busy=%b done_cnt=%0d exp=0/0", busy, n_done); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
        do_start;
        checks++; if (timeout_err !== 1'b0 || stage !== 4'd0 || sample_ready !== 1'b1) begin failures++; $display("FAIL to_clear got err=%b stage=%0d ready=%b exp=0/0/1", timeout_err, stage, sample_ready); end
    endtask

    task automatic test_reset_mid_cfill;
        int bad, cyc;
        run_bad = 0; n_done = 0;
        for (int s = 0; s < 3; s++) run_stage(16'(16'h7000 + s * 64));
        load_stage(0, 16'h7300, bad, cyc);
        repeat (5) @(negedge clk);
        checks++; if (stage !== 4'd3 || busy !== 1'b1 || run_bad != 0) begin failures++; $display("FAIL rst_reach_cfill got stage=%0d busy=%b bad=%0d exp=3/1/0", stage, busy, run_bad); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({sample_ready, we_regs, fill_regs, start_calc, busy, done, timeout_err} !== 7'b0 || stage !== 4'd0 || data_in !== 16'h0) begin failures++; $display("FAIL rst_async got ctrl=%b stage=%0d data=%h exp=0/0/0", {sample_ready, we_regs, fill_regs, start_calc, busy, done, timeout_err}, stage, data_in); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (n_done != 0 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_done got done_cnt=%0d busy=%b exp=0/0", n_done, busy); end
        n_fill = 0;
        do_start;
        for (int s = 0; s < 5; s++) run_stage(16'(16'h8000 + s * 64));
        checks++; if (done !== 1'b1 || n_fill != 5 || run_bad != 0) begin failures++; $display("FAIL rst_rerun got done=%b fill=%0d bad=%0d exp=1/5/0", done, n_fill, run_bad); end
        @(negedge clk);
    endtask

    task automatic test_ignored;
        int bad, cyc;
        run_bad = 0;
        do_start;
        calc_finish = 1'b1;
        repeat (2) @(negedge clk);
        calc_finish = 1'b0;
        checks++; if (sample_ready !== 1'b1 || addr_counter !== 5'd0 || stage !== 4'd0 || fill_regs !== 1'b0) begin failures++; $display("FAIL ign_finish_in_load got ready=%b addr=%0d stage=%0d fill=%b exp=1/0/0/0", sample_ready, addr_counter, stage, fill_regs); end
        for (int s = 0; s < 4; s++) run_stage(16'(16'h9000 + s * 64));
        load_stage(0, 16'h9400, bad, cyc);
        wait_calc(cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (stage !== 4'd4 || busy !== 1'b1 || sample_ready !== 1'b0) begin failures++; $display("FAIL ign_start_in_wait got stage=%0d busy=%b ready=%b exp=4/1/0", stage, busy, sample_ready); end
        finish_after(5);
        checks++; if (done !== 1'b1 || run_bad != 0) begin failures++; $display("FAIL ign_done got done=%b bad=%0d exp=1/0", done, run_bad); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || sample_ready !== 1'b0) begin failures++; $display("FAIL ign_start_in_done got done=%b busy=%b ready=%b exp=0/0/0", done, busy, sample_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_stays_idle got=%b exp=0", busy); end
    endtask

    task automatic test_finish_at_timeout;
        int bad, cyc;
        do_start;
        load_stage(0, 16'hA000, bad, cyc);
        wait_calc(cyc);
        repeat (1024) @(negedge clk);
        calc_finish = 1'b1;
        @(negedge clk);
        calc_finish = 1'b0;
        checks++; if (timeout_err !== 1'b0 || stage !== 4'd1) begin failures++; $display("FAIL tie_priority got err=%b stage=%0d exp=0/1", timeout_err, stage); end
        checks++; if (sample_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL tie_next_load got ready=%b busy=%b exp=1/1", sample_ready, busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_full_run;
        test_backpressure;
        test_timeout;
        test_reset_mid_cfill;
        test_ignored;
        test_finish_at_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
